traffic_request_encoder: RTL

//  Front end of the traffic-light controller. Conditions raw vehicle loop sensors into the 8-bit
//  one-hot NSEW request vector the controller consumes, and closes the loop on the controller's

---
 rtl/traffic_request_encoder_if.sv | 32 +++
 rtl/traffic_request_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_encoder_if.sv
// ---------------------------------------------------------------------------
// traffic_request_encoder_if
// Groups the loop-sensor inputs, the controller light codes fed back to the
// encoder, and the request/status outputs of traffic_request_encoder.
//   SENSOR   8  raw vehicle loops, [1:0]=NS [3:2]=EW [5:4]=NW [7:6]=NE
//   NS..NE   2  controller light code per approach (10 green, 01 yellow, 00 red)
//   NSEW     8  one-hot-or-zero request vector, same bit map as SENSOR
//   PENDING  4  latched requests per approach, [0]=NS [1]=EW [2]=NW [3]=NE
//   ERR      1  sticky service-timeout flag
// master : the encoder side (consumes sensors/lights, produces requests)
// slave  : the environment side (sensors and controller)
// ---------------------------------------------------------------------------
interface traffic_request_encoder_if;
   logic [7:0] SENSOR;
   logic [1:0] NS;
   logic [1:0] EW;
   logic [1:0] NW;
   logic [1:0] NE;
   logic [7:0] NSEW;
   logic [3:0] PENDING;
   logic       ERR;

   modport master (
      input  SENSOR, NS, EW, NW, NE,
      output NSEW, PENDING, ERR
   );

   modport slave (
      output SENSOR, NS, EW, NW, NE,
      input  NSEW, PENDING, ERR
   );
endinterface

// File: rtl/traffic_request_encoder.sv
// ---------------------------------------------------------------------------
// traffic_request_encoder
// Front end of the traffic-light controller. Synchronises and debounces the
// eight vehicle loops, latches one request per approach, arbitrates the
// latched requests round-robin and presents exactly one of them at a time on
// NSEW. A presented request is held until its approach is seen green, kept
// for HOLD_CYC more cycles, then retired, followed by one all-zero cycle.
// Ports:
//   CLK   clock
//   RST   asynchronous active-high reset
//   bus   traffic_request_encoder_if.master (SENSOR, NS, EW, NW, NE in;
//         NSEW, PENDING, ERR out)
// Parameters:
//   DEB_CYC   synced-high cycles that qualify a detection (>=1)
//   HOLD_CYC  cycles a request stays up after its approach is first green
//   TIMEOUT   cycles in PRESENT before ERR is raised
//   CW        counter width, must hold max(DEB_CYC, HOLD_CYC, TIMEOUT)
// ---------------------------------------------------------------------------
module traffic_request_encoder #(
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned HOLD_CYC = 8,
   parameter int unsigned TIMEOUT  = 1023,
   parameter int unsigned CW       = 10
) (
   input  logic                      CLK,
   input  logic                      RST,
   traffic_request_encoder_if.master bus
);

   localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CYC);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

   // ------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous loops
   // ------------------------------------------------------------------
   logic [7:0] s1_reg;
   logic [7:0] s2_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= bus.SENSOR;
         s2_reg <= s1_reg;
      end
   end

   // ------------------------------------------------------------------
   // Per-bit debounce. The counter saturates at DEB_CYC, so det fires once
   // per qualified high period and re-arms only after s2 drops.
   // ------------------------------------------------------------------
   logic [7:0] det;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_deb
         logic [CW-1:0] cnt_reg;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               cnt_reg <= '0;
            end else if (!s2_reg[gi]) begin
               cnt_reg <= '0;
            end else if (cnt_reg != DEB_MAX) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign det[gi] = s2_reg[gi] && (cnt_reg == DEB_LAST);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Per-approach detection summary
   // ------------------------------------------------------------------
   logic [3:0] det_any;
   logic [3:0] det_upper;   // upper loop of the pair, only when the lower is quiet

   generate
      for (gi = 0; gi < 4; gi++) begin : g_pair
         assign det_any[gi]   = det[2*gi] | det[2*gi+1];
         assign det_upper[gi] = det[2*gi+1] & ~det[2*gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   state_t        state_reg, state_next;
   logic [1:0]    sel_reg, sel_next;
   logic [1:0]    last_reg, last_next;
   logic [7:0]    nsew_reg, nsew_next;
   logic [3:0]    pending_reg, pending_next;
   logic [3:0]    loop_reg, loop_next;
   logic [CW-1:0] tmo_reg, tmo_next;
   logic [CW-1:0] hold_reg, hold_next;
   logic          err_reg, err_next;
   logic          retire;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= IDLE;
         sel_reg     <= '0;
         last_reg    <= 2'd3;
         nsew_reg    <= '0;
         pending_reg <= '0;
         loop_reg    <= '0;
         tmo_reg     <= '0;
         hold_reg    <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sel_reg     <= sel_next;
         last_reg    <= last_next;
         nsew_reg    <= nsew_next;
         pending_reg <= pending_next;
         loop_reg    <= loop_next;
         tmo_reg     <= tmo_next;
         hold_reg    <= hold_next;
         err_reg     <= err_next;
      end
   end

   // ------------------------------------------------------------------
   // Round-robin pick: first pending approach after last_reg. Scanning
   // from the farthest candidate down lets the nearest one win.
   // ------------------------------------------------------------------
   logic       pick_valid;
   logic [1:0] pick;

   always_comb begin
      logic [1:0] cand;
      pick_valid = 1'b0;
      pick       = '0;
      cand       = '0;
      for (int k = 4; k >= 1; k--) begin
         cand = last_reg + 2'(k);
         if (pending_reg[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   // Light code of the selected approach; the others are never looked at.
   logic [1:0] light_sel;

   always_comb begin
      light_sel = 2'b00;
      case (sel_reg)
         2'd0:    light_sel = bus.NS;
         2'd1:    light_sel = bus.EW;
         2'd2:    light_sel = bus.NW;
         default: light_sel = bus.NE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM next state and registered outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      last_next  = last_reg;
      nsew_next  = nsew_reg;
      tmo_next   = tmo_reg;
      hold_next  = hold_reg;
      err_next   = err_reg;
      retire     = 1'b0;

      case (state_reg)
         IDLE: begin
            nsew_next = '0;
            if (pick_valid) begin
               sel_next  = pick;
               nsew_next[{pick, loop_reg[pick]}] = 1'b1;
               tmo_next  = '0;
               state_next = PRESENT;
            end
         end

         PRESENT: begin
            if (light_sel == 2'b10) begin
               hold_next  = '0;
               state_next = HOLD;
            end else begin
               // The request stays up after a timeout; ERR only reports it.
               if (tmo_reg == TMO_LAST) begin
                  err_next = 1'b1;
               end
               if (tmo_reg != TMO_MAX) begin
                  tmo_next = tmo_reg + 1'b1;
               end
            end
         end

         HOLD: begin
            // Green dropping during HOLD does not shorten it.
            if (hold_reg == HOLD_LAST) begin
               retire     = 1'b1;
               last_next  = sel_reg;
               nsew_next  = '0;
               state_next = IDLE;
            end else begin
               hold_next = hold_reg + 1'b1;
            end
         end

         default: begin
            nsew_next  = '0;
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch. A det on an already-pending approach is ignored, which
   // also discards dets on the selected approach during HOLD (its bit is
   // still set until the retire edge, where the clear wins).
   // ------------------------------------------------------------------
   always_comb begin
      pending_next = pending_reg;
      loop_next    = loop_reg;
      for (int d = 0; d < 4; d++) begin
         if (retire && (sel_reg == 2'(d))) begin
            pending_next[d] = 1'b0;
         end else if (det_any[d] && !pending_reg[d]) begin
            pending_next[d] = 1'b1;
            loop_next[d]    = det_upper[d];
         end
      end
   end

   assign bus.NSEW    = nsew_reg;
   assign bus.PENDING = pending_reg;
   assign bus.ERR     = err_reg;

endmodule
